// File: rtl/weight_mem_sequencer_pkg.sv
// Shared constants for the weight-memory sequencer: state encoding and default widths.
package weight_mem_sequencer_pkg;

    localparam int DEF_CNT_W = 8;
    localparam int DEF_IDX_W = 2;

    localparam logic [2:0] S_IDLE     = 3'd0;
    localparam logic [2:0] S_LOAD     = 3'd1;
    localparam logic [2:0] S_TRAIN    = 3'd2;
    localparam logic [2:0] S_COMMIT   = 3'd3;
    localparam logic [2:0] S_ROLLBACK = 3'd4;
    localparam logic [2:0] S_UPDATE   = 3'd5;
    localparam logic [2:0] S_FINISH   = 3'd6;
    localparam logic [2:0] S_DONE     = 3'd7;

    // States that stream one full weight set, one word per cycle
    function automatic logic is_burst(input logic [2:0] state);
        return (state == S_LOAD) || (state == S_COMMIT) ||
               (state == S_ROLLBACK) || (state == S_FINISH);
    endfunction

endpackage

// File: rtl/burst_counter.sv
// Word index counter for the burst states; restarts from 0 and flags the last word.
module burst_counter #(
    parameter int IDX_W       = 2,
    parameter int NUM_WEIGHTS = 4
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_start,
    input  logic             i_en,
    output logic [IDX_W-1:0] o_idx,
    output logic             o_tc
);

    logic [IDX_W-1:0] r_idx;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_idx <= '0;
        end else if (i_start) begin
            r_idx <= '0;
        end else if (i_en) begin
            r_idx <= r_idx + IDX_W'(1);
        end
    end

    assign o_idx = r_idx;
    assign o_tc  = (r_idx == IDX_W'(NUM_WEIGHTS - 1));

endmodule

// File: rtl/weight_mem_sequencer.sv
// Sequences ROM load, per-epoch commit/rollback, weight update and final read-out
// of the weight-memory subsystem.
//
// state    | meaning
// IDLE     | waiting for start
// LOAD     | copy initial guess from ROM into the buffers
// TRAIN    | datapath running an epoch
// COMMIT   | store improved weights into best and old buffers
// ROLLBACK | read old weights back after a worse epoch
// UPDATE   | rewind buffer pointers, decide continue or finish
// FINISH   | stream best weights out
// DONE     | one-cycle completion pulse
module weight_mem_sequencer
    import weight_mem_sequencer_pkg::*;
#(
    parameter int NUM_WEIGHTS = 4,
    parameter int MAX_EPOCHS  = 255,
    parameter int CNT_W       = DEF_CNT_W,
    parameter int IDX_W       = DEF_IDX_W
) (
    input  logic             CLK,
    input  logic             RESET,
    input  logic             start,
    input  logic             abort,
    input  logic             epoch_done,
    input  logic             err_improved,
    input  logic             converged,
    output logic             initial_read_flag,
    output logic             write_training,
    output logic             old_weight_rd,
    output logic             update_weight,
    output logic             finish,
    output logic             write_en,
    output logic [IDX_W-1:0] word_idx,
    output logic [CNT_W-1:0] epoch_cnt,
    output logic             busy,
    output logic             done
);

    logic [2:0]       r_state;
    logic [2:0]       w_state_nxt;
    logic             r_stop;
    logic [CNT_W-1:0] r_epoch_cnt;
    logic [CNT_W-1:0] w_cnt_inc;
    logic             w_tc;
    logic             w_continue;
    logic             w_enter_load;

    logic r_init_rd, r_wr_train, r_old_rd, r_update, r_finish, r_wr_en, r_busy, r_done;

    // The index keeps counting only while the same burst state persists
    assign w_continue   = is_burst(r_state) && (w_state_nxt == r_state);
    assign w_enter_load = (r_state == S_IDLE) && (w_state_nxt == S_LOAD);
    assign w_cnt_inc    = (r_epoch_cnt >= CNT_W'(MAX_EPOCHS)) ? r_epoch_cnt
                                                              : r_epoch_cnt + CNT_W'(1);

    burst_counter #(
        .IDX_W       (IDX_W),
        .NUM_WEIGHTS (NUM_WEIGHTS)
    ) u_burst_counter (
        .i_clk   (CLK),
        .i_rst_n (RESET),
        .i_start (!w_continue),
        .i_en    (w_continue),
        .o_idx   (word_idx),
        .o_tc    (w_tc)
    );

    always_comb begin
        w_state_nxt = r_state;
        if (abort) begin
            w_state_nxt = S_IDLE;
        end else begin
            case (r_state)
                S_IDLE:     if (start) w_state_nxt = S_LOAD;
                S_LOAD:     if (w_tc) w_state_nxt = S_TRAIN;
                S_TRAIN:    if (epoch_done) w_state_nxt = err_improved ? S_COMMIT : S_ROLLBACK;
                S_COMMIT:   if (w_tc) w_state_nxt = S_UPDATE;
                S_ROLLBACK: if (w_tc) w_state_nxt = S_UPDATE;
                // Decision uses the count this UPDATE is about to record
                S_UPDATE:   w_state_nxt = (r_stop || (w_cnt_inc >= CNT_W'(MAX_EPOCHS)))
                                          ? S_FINISH : S_TRAIN;
                S_FINISH:   if (w_tc) w_state_nxt = S_DONE;
                S_DONE:     w_state_nxt = S_IDLE;
                default:    w_state_nxt = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            r_state     <= S_IDLE;
            r_stop      <= 1'b0;
            r_epoch_cnt <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (w_enter_load) begin
                r_stop <= 1'b0;
            end else if (!abort && (r_state == S_TRAIN) && epoch_done) begin
                r_stop <= converged;
            end
            if (w_enter_load) begin
                r_epoch_cnt <= '0;
            end else if (!abort && (r_state == S_UPDATE)) begin
                r_epoch_cnt <= w_cnt_inc;
            end
        end
    end

    // Outputs are decoded from the next state so they line up with the state register
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            r_init_rd  <= 1'b0;
            r_wr_train <= 1'b0;
            r_old_rd   <= 1'b0;
            r_update   <= 1'b0;
            r_finish   <= 1'b0;
            r_wr_en    <= 1'b0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
        end else begin
            r_init_rd  <= (w_state_nxt == S_LOAD);
            r_wr_train <= (w_state_nxt == S_COMMIT);
            r_old_rd   <= (w_state_nxt == S_ROLLBACK);
            r_update   <= (w_state_nxt == S_UPDATE);
            r_finish   <= (w_state_nxt == S_FINISH);
            r_wr_en    <= (w_state_nxt == S_FINISH);
            r_busy     <= (w_state_nxt != S_IDLE);
            r_done     <= (w_state_nxt == S_DONE);
        end
    end

    assign initial_read_flag = r_init_rd;
    assign write_training    = r_wr_train;
    assign old_weight_rd     = r_old_rd;
    assign update_weight     = r_update;
    assign finish            = r_finish;
    assign write_en          = r_wr_en;
    assign busy              = r_busy;
    assign done              = r_done;
    assign epoch_cnt         = r_epoch_cnt;

endmodule

// File: tb/tb_weight_mem_sequencer.sv
// Directed bench for weight_mem_sequencer with hand-computed cycle-by-cycle expectations.
module tb_weight_mem_sequencer;

    localparam int NW     = 4;
    localparam int MAX_EP = 3;

    // Strobe vector: {busy, done, finish, write_en, update, old_rd, write_training, init_rd}
    localparam logic [7:0] E_IDLE  = 8'h00;
    localparam logic [7:0] E_LOAD  = 8'h81;
    localparam logic [7:0] E_TRAIN = 8'h80;
    localparam logic [7:0] E_COMM  = 8'h82;
    localparam logic [7:0] E_RB    = 8'h84;
    localparam logic [7:0] E_UPD   = 8'h88;
    localparam logic [7:0] E_FIN   = 8'hB0;
    localparam logic [7:0] E_DONE  = 8'hC0;

    logic       CLK = 1'b0;
    logic       RESET = 1'b0;
    logic       start = 1'b0, abort = 1'b0, epoch_done = 1'b0;
    logic       err_improved = 1'b0, converged = 1'b0;
    logic       initial_read_flag, write_training, old_weight_rd, update_weight;
    logic       finish, write_en, busy, done;
    logic [1:0] word_idx;
    logic [7:0] epoch_cnt;
    logic [7:0] w_strb;

    int n_vec = 0;
    int n_err = 0;

    always #5 CLK = ~CLK;

    weight_mem_sequencer #(
        .NUM_WEIGHTS (NW),
        .MAX_EPOCHS  (MAX_EP),
        .CNT_W       (8),
        .IDX_W       (2)
    ) dut (
        .CLK               (CLK),
        .RESET             (RESET),
        .start             (start),
        .abort             (abort),
        .epoch_done        (epoch_done),
        .err_improved      (err_improved),
        .converged         (converged),
        .initial_read_flag (initial_read_flag),
        .write_training    (write_training),
        .old_weight_rd     (old_weight_rd),
        .update_weight     (update_weight),
        .finish            (finish),
        .write_en          (write_en),
        .word_idx          (word_idx),
        .epoch_cnt         (epoch_cnt),
        .busy              (busy),
        .done              (done)
    );

    assign w_strb = {busy, done, finish, write_en, update_weight,
                     old_weight_rd, write_training, initial_read_flag};

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    // Check the current cycle, then advance one cycle
    task automatic exp_cyc(input string tag, input logic [7:0] s, input int idx, input int cnt);
        chk({tag, "_strb"}, 32'(w_strb), 32'(s));
        chk({tag, "_idx"}, 32'(word_idx), 32'(idx));
        chk({tag, "_cnt"}, 32'(epoch_cnt), 32'(cnt));
        step();
    endtask

    task automatic burst(input string tag, input logic [7:0] s, input int cnt);
        for (int i = 0; i < NW; i++) exp_cyc($sformatf("%s%0d", tag, i), s, i, cnt);
    endtask

    task automatic pulse_start();
        start = 1'b1;
        step();
        start = 1'b0;
    endtask

    task automatic pulse_epoch(input logic imp, input logic conv);
        epoch_done   = 1'b1;
        err_improved = imp;
        converged    = conv;
        step();
        epoch_done   = 1'b0;
        err_improved = 1'b0;
        converged    = 1'b0;
    endtask

    initial begin
        // Reset, then reset again in the middle of LOAD
        step();
        step();
        exp_cyc("rst", E_IDLE, 0, 0);
        RESET = 1'b1;
        step();
        pulse_start();
        exp_cyc("pre_load0", E_LOAD, 0, 0);
        chk("pre_load1_strb", 32'(w_strb), 32'(E_LOAD));
        RESET = 1'b0;
        #1;
        chk("midrst_strb", 32'(w_strb), 32'(E_IDLE));
        chk("midrst_idx", 32'(word_idx), 32'd0);
        step();
        exp_cyc("rst_hold", E_IDLE, 0, 0);
        RESET = 1'b1;
        step();
        exp_cyc("post_rst", E_IDLE, 0, 0);

        // Load then a single committed epoch
        pulse_start();
        burst("load", E_LOAD, 0);
        exp_cyc("train0", E_TRAIN, 0, 0);
        pulse_epoch(1'b1, 1'b0);
        burst("commit", E_COMM, 0);
        exp_cyc("upd0", E_UPD, 0, 0);
        exp_cyc("train1", E_TRAIN, 0, 1);

        // start while busy is ignored
        pulse_start();
        exp_cyc("ign_start", E_TRAIN, 0, 1);

        // Rollback with converged, stray epoch_done during ROLLBACK must not clear stop
        pulse_epoch(1'b0, 1'b1);
        exp_cyc("rb0", E_RB, 0, 1);
        epoch_done   = 1'b1;
        err_improved = 1'b1;
        exp_cyc("rb1", E_RB, 1, 1);
        epoch_done   = 1'b0;
        err_improved = 1'b0;
        exp_cyc("rb2", E_RB, 2, 1);
        exp_cyc("rb3", E_RB, 3, 1);
        exp_cyc("upd_rb", E_UPD, 0, 1);
        burst("fin", E_FIN, 2);
        exp_cyc("done", E_DONE, 0, 2);
        exp_cyc("idle_a", E_IDLE, 0, 2);
        exp_cyc("idle_b", E_IDLE, 0, 2);

        // Epoch limit of 3 with every epoch improving
        pulse_start();
        burst("lim_load", E_LOAD, 0);
        for (int ep = 0; ep < MAX_EP; ep++) begin
            exp_cyc($sformatf("lim_train%0d", ep), E_TRAIN, 0, ep);
            pulse_epoch(1'b1, 1'b0);
            burst($sformatf("lim_c%0d_", ep), E_COMM, ep);
            exp_cyc($sformatf("lim_upd%0d", ep), E_UPD, 0, ep);
        end
        burst("lim_fin", E_FIN, MAX_EP);
        exp_cyc("lim_done", E_DONE, 0, MAX_EP);
        exp_cyc("lim_idle0", E_IDLE, 0, MAX_EP);
        exp_cyc("lim_idle1", E_IDLE, 0, MAX_EP);

        // Abort in the 2nd COMMIT cycle together with epoch_done
        pulse_start();
        burst("ab_load", E_LOAD, 0);
        exp_cyc("ab_train0", E_TRAIN, 0, 0);
        pulse_epoch(1'b1, 1'b0);
        burst("ab_c", E_COMM, 0);
        exp_cyc("ab_upd", E_UPD, 0, 0);
        exp_cyc("ab_train1", E_TRAIN, 0, 1);
        pulse_epoch(1'b1, 1'b0);
        exp_cyc("ab_cc0", E_COMM, 0, 1);
        abort        = 1'b1;
        epoch_done   = 1'b1;
        err_improved = 1'b1;
        exp_cyc("ab_cc1", E_COMM, 1, 1);
        abort        = 1'b0;
        epoch_done   = 1'b0;
        err_improved = 1'b0;
        for (int i = 0; i < 6; i++) exp_cyc($sformatf("ab_idle%0d", i), E_IDLE, 0, 1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
